// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU request scheduler: opcode type, frame
// type bits, frame geometry, frame assembly and the CRC-4 used in the CMD frame.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_RSV = 3'd7
  } operation_t;

  localparam logic DATA_TYPE  = 1'b0;
  localparam logic CMD_TYPE   = 1'b1;
  localparam int   FRAME_BITS = 11;
  localparam int   PKT_FRAMES = 9;

  // One frame as it leaves the line MSB first: start, type, payload, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic type_bit,
                                                       input logic [7:0] payload);
    return {1'b0, type_bit, payload, 1'b1};
  endfunction

  // CRC-4, x^4+x+1, init 0, over {B, A, 1'b1, op} taken MSB first.
  function automatic logic [3:0] crc4_generate(input logic [31:0] b,
                                               input logic [31:0] a,
                                               input logic [2:0]  op);
    logic [67:0] data;
    logic [3:0]  crc;
    logic        fb;
    data = {b, a, 1'b1, op};
    crc  = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ data[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_frame_ser.sv
// Frame serializer: parallel-loads one 11-bit frame, shifts it out MSB first on
// sin (idle high) and flags the cycle in which the frame's last bit is on sin.
module alu_frame_ser
  import alu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  shift,
  output logic                  sin,
  output logic                  eof
);

  logic [FRAME_BITS-1:0] shreg;
  // One-hot marker travelling alongside the data; reaches the top on the last bit.
  logic [FRAME_BITS-1:0] mark;

  // Load has priority over shift; ones shift in so the line rests high afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '1;
      mark  <= '0;
    end else if (load) begin
      shreg <= frame;
      mark  <= FRAME_BITS'(1);
    end else if (shift) begin
      shreg <= {shreg[FRAME_BITS-2:0], 1'b1};
      mark  <= {mark[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign sin = shreg[FRAME_BITS-1];
  assign eof = mark[FRAME_BITS-1];

endmodule

// File: rtl/alu_req_sched.sv
// Two-requester round-robin scheduler that packs operands and opcode into a
// 9-frame serial packet for the ALU. FSM IDLE -> SEND -> GAP -> IDLE.
// Handshake: reqN_ready is only high in IDLE for the arbitration winner; a
// request is taken on the rising edge where reqN_valid & reqN_ready are both 1.
// Optional macro ALU_SCHED_CRC_INJ_EN adds reqN_crc_err inputs that corrupt the
// transmitted CRC by +1 for the accepted packet.
module alu_req_sched
  import alu_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ALU_SCHED_CRC_INJ_EN
  input  logic        req0_crc_err,
  input  logic        req1_crc_err,
`endif
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        sin,
  output logic        busy,
  output logic        grant_id,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]  state;
  logic        last_grant;
  logic [31:0] a_lat, b_lat;
  operation_t  op_lat;
  logic [3:0]  crc_lat;
  logic [3:0]  bit_cnt;
  logic [3:0]  frame_cnt;
  logic [3:0]  gap_cnt;

  logic        pick1, accept, in_err;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_op;
  logic [3:0]  in_crc;
  logic        ser_load, ser_shift, ser_eof, frame_end;
  logic [FRAME_BITS-1:0] ser_frame;
  logic [3:0]  next_idx;
  logic [63:0] shifted;

`ifdef ALU_SCHED_CRC_INJ_EN
  assign in_err = pick1 ? req1_crc_err : req0_crc_err;
`else
  assign in_err = 1'b0;
`endif

  // Round-robin arbiter and operand select for the current IDLE cycle.
  always_comb begin
    pick1  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    accept = rst_n & (state == IDLE) & (req0_valid | req1_valid);
    in_a   = pick1 ? req1_a  : req0_a;
    in_b   = pick1 ? req1_b  : req0_b;
    in_op  = pick1 ? req1_op : req0_op;
    in_crc = crc4_generate(in_b, in_a, in_op) + {3'b000, in_err};
  end

  assign req0_ready = accept & ~pick1;
  assign req1_ready = accept &  pick1;

  assign frame_end = (state == SEND) && (bit_cnt == 4'(FRAME_BITS - 1));
  assign done      = frame_end && (frame_cnt == 4'(PKT_FRAMES - 1));
  assign busy      = (state != IDLE);
  assign ser_shift = (state == SEND);

  // Next frame for the serializer: frame 0 straight from the winner's inputs,
  // later frames from the latched operands, the CMD frame last.
  always_comb begin
    ser_load  = 1'b0;
    ser_frame = '1;
    next_idx  = frame_cnt + 4'd1;
    shifted   = {b_lat, a_lat} >> {~next_idx[2:0], 3'b000};
    if (accept) begin
      ser_load  = 1'b1;
      ser_frame = make_frame(DATA_TYPE, in_b[31:24]);
    end else if (ser_eof && (state == SEND) && (frame_cnt != 4'(PKT_FRAMES - 1))) begin
      ser_load = 1'b1;
      if (next_idx == 4'(PKT_FRAMES - 1))
        ser_frame = make_frame(CMD_TYPE, {1'b0, op_lat, crc_lat});
      else
        ser_frame = make_frame(DATA_TYPE, shifted[7:0]);
    end
  end

  // FSM, latched request, and bit/frame/gap counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      a_lat      <= '0;
      b_lat      <= '0;
      op_lat     <= OP_ADD;
      crc_lat    <= '0;
      bit_cnt    <= '0;
      frame_cnt  <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SEND;
            grant_id   <= pick1;
            last_grant <= pick1;
            a_lat      <= in_a;
            b_lat      <= in_b;
            op_lat     <= operation_t'(in_op);
            crc_lat    <= in_crc;
            bit_cnt    <= '0;
            frame_cnt  <= '0;
          end
        end
        SEND: begin
          if (frame_end) begin
            bit_cnt <= '0;
            if (done) begin
              state   <= GAP;
              gap_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 4'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) state <= IDLE;
          else gap_cnt <= gap_cnt + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  alu_frame_ser u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .frame (ser_frame),
    .shift (ser_shift),
    .sin   (sin),
    .eof   (ser_eof)
  );

endmodule

// File: tb/tb_alu_req_sched.sv
// Bench for alu_req_sched: random operands, packet frames checked against a
// reference built from the frame/packet rules and a CRC computed by polynomial
// long division.
module tb_alu_req_sched;

  localparam int GAP = 2;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        e0, e1;
  logic        sin, busy, grant_id, done;

  int checks = 0;
  int errors = 0;
  logic last_gid = 1'b0;

  alu_req_sched #(.GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef ALU_SCHED_CRC_INJ_EN
    .req0_crc_err (e0),
    .req1_crc_err (e1),
`endif
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .sin        (sin),
    .busy       (busy),
    .grant_id   (grant_id),
    .done       (done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference CRC: remainder of ({B,A,1,op} * x^4) mod (x^4+x+1).
  function automatic logic [3:0] crc_ref(input logic [31:0] b, input logic [31:0] a,
                                         input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic rand_ops();
    req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
    req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits for the expected grant, then captures and checks all 99 packet cycles.
  // n returns the number of cycles waited for ready from the call point.
  task automatic run_packet(input logic exp_id, input bit hold_valid, input bit raise0,
                            output int n);
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  crc;
    logic [7:0]  pl;
    logic [10:0] exp_q[$];
    logic [10:0] got, exp_w;
    int done_bad, busy_bad, gid_bad, rdy_bad, sin_bad;
    n = 0; sin_bad = 0; got = '0;
    #1;
    while (req0_ready !== 1'b1 && req1_ready !== 1'b1 && n < 400) begin
      if (sin !== 1'b1 || grant_id !== last_gid) sin_bad++;
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 400) begin
      errors++; $display("FAIL ready_timeout: waited %0d cycles, required < 400", n);
      return;
    end
    checks++;
    if (sin_bad != 0) begin
      errors++; $display("FAIL idle_line: %0d bad idle cycles (sin/grant_id), required 0", sin_bad);
    end
    checks++;
    if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL grant: ready1/0=%b%b, required grant to req%0d", req1_ready, req0_ready, exp_id);
    end
    if (exp_id) begin a = req1_a; b = req1_b; op = req1_op; crc = crc_ref(b, a, op) + {3'b0, e1}; end
    else        begin a = req0_a; b = req0_b; op = req0_op; crc = crc_ref(b, a, op) + {3'b0, e0}; end
    for (int f = 0; f < 9; f++) begin
      if (f < 4)      pl = b[31 - 8*f -: 8];
      else if (f < 8) pl = a[31 - 8*(f-4) -: 8];
      else            pl = {1'b0, op, crc};
      exp_q.push_back({1'b0, (f == 8), pl, 1'b1});
    end
    done_bad = 0; busy_bad = 0; gid_bad = 0; rdy_bad = 0;
    for (int cyc = 1; cyc <= 99; cyc++) begin
      @(negedge clk); #1;
      got = {got[9:0], sin};
      if (done !== (cyc == 99)) done_bad++;
      if (busy !== 1'b1) busy_bad++;
      if (grant_id !== exp_id) gid_bad++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) rdy_bad++;
      if (cyc % 11 == 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        if (got !== exp_w) begin
          errors++; $display("FAIL frame%0d: got %h, required %h", cyc/11 - 1, got, exp_w);
        end
      end
      if (cyc == 1 && !hold_valid) begin
        if (exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
      if (cyc == 30) begin
        rand_ops();
        if (raise0) req0_valid = 1'b1;
      end
    end
    checks++;
    if (done_bad != 0) begin errors++; $display("FAIL done_pulse: %0d bad cycles, required only cycle 99", done_bad); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL busy: %0d cycles low in packet, required 0", busy_bad); end
    checks++;
    if (gid_bad != 0) begin errors++; $display("FAIL grant_id: %0d cycles wrong, required %0d", gid_bad, exp_id); end
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL ready_busy: %0d cycles ready high in packet, required 0", rdy_bad); end
    last_gid = exp_id;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({sin, busy, done, req0_ready, req1_ready, grant_id} !== 6'b100000) begin
        errors++;
        $display("FAIL reset: sin,busy,done,r0,r1,gid=%b%b%b%b%b%b, required 100000",
                 sin, busy, done, req0_ready, req1_ready, grant_id);
      end
    end
    req0_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    req0_a = 32'h1; req0_b = 32'h2; req0_op = 3'b100; req0_valid = 1'b1;
    run_packet(1'b0, 1'b0, 1'b0, n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL single_wait: %0d, required 0", n); end
  endtask

  task automatic test_contention();
    int n;
    do_reset();
    rand_ops();
    req0_valid = 1'b1; req1_valid = 1'b1;
    run_packet(1'b0, 1'b0, 1'b0, n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL contention_first_wait: %0d, required 0", n); end
    run_packet(1'b1, 1'b0, 1'b0, n);
    checks++;
    if (n != GAP + 1) begin errors++; $display("FAIL contention_gap: %0d, required %0d", n, GAP + 1); end
  endtask

  task automatic test_fairness();
    int n;
    logic exp_seq[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    rand_ops();
    req1_valid = 1'b1;
    run_packet(1'b1, 1'b1, 1'b1, n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL fair_first_wait: %0d, required 0", n); end
    for (int i = 0; i < 4; i++) begin
      run_packet(exp_seq[i], (i < 2), 1'b0, n);
      checks++;
      if (n != GAP + 1) begin errors++; $display("FAIL fair_gap%0d: %0d, required %0d", i, n, GAP + 1); end
    end
  endtask

  task automatic test_random();
    int n;
    logic id;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      id = 1'($urandom_range(0, 1));
      if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
      run_packet(id, 1'b0, 1'b0, n);
    end
  endtask

  task automatic test_abort();
    int n, done_seen;
    do_reset();
    rand_ops();
    req0_valid = 1'b1;
    n = 0; done_seen = 0;
    #1;
    while (req0_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk); #1;
      if (done !== 1'b0) done_seen++;
      if (cyc == 1) req0_valid = 1'b0;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      if (done !== 1'b0) done_seen++;
      checks++;
      if (sin !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_line: sin=%b busy=%b, required sin=1 busy=0", sin, busy);
      end
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL abort_done: %0d pulses, required 0", done_seen); end
    rst_n = 1'b1;
    rand_ops();
    req0_valid = 1'b1;
    run_packet(1'b0, 1'b0, 1'b0, n);
  endtask

`ifdef ALU_SCHED_CRC_INJ_EN
  task automatic test_crc_inj();
    int n;
    rand_ops();
    e0 = 1'b1;
    req0_valid = 1'b1;
    run_packet(1'b0, 1'b0, 1'b0, n);
    e0 = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; e0 = 1'b0; e1 = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_random();
    test_abort();
`ifdef ALU_SCHED_CRC_INJ_EN
    test_crc_inj();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_req_sched.md
ALU_REQ_SCHED -- requirements
Module: alu_req_sched

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2: minimum number of idle-high sin cycles between packets, legal range 1..15.
REQ-002 clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N has a pending calculation.
REQ-005 req0_ready / req1_ready  output  1  request N is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands A and B.
REQ-007 req0_op / req1_op  input  3  operation code, sent unmodified, including illegal codes.
REQ-008 sin  output  1  serial line to the ALU, idle high.
REQ-009 busy  output  1  a packet is being sent or the block is in GAP.
REQ-010 grant_id  output  1  requester whose packet is in flight.
REQ-011 done  output  1  one-cycle pulse when the last packet bit is driven.

Function
REQ-012 Frame format SHALL be 11 bits, one bit per clk: start 0, type bit (0 = DATA_TYPE, 1 = CMD_TYPE), 8 payload bits MSB first, stop 1.
REQ-013 Packet SHALL be 9 frames, 99 cycles: B[31:24], B[23:16], B[15:8], B[7:0], A[31:24] .. A[7:0] as DATA frames, then one CMD frame with payload {1'b0, op, crc}.
REQ-014 crc SHALL be CRC-4, polynomial x^4+x+1, init 4'h0, computed over the 68-bit vector {B, A, 1'b1, op}, MSB first.
REQ-015 FSM states SHALL be IDLE, SEND and GAP; reset state is IDLE.
REQ-016 In IDLE, reqN_ready SHALL be 1 only for the arbitration winner among requesters with valid=1; both readies are 0 outside IDLE or when no valid is set.
REQ-017 Arbitration SHALL be round-robin: if both valids are set, the requester not granted last wins; the last-grant register resets to 1, so req0 wins first.
REQ-018 On valid&ready, the block SHALL latch A, B, op and grant_id, compute crc, and enter SEND.
REQ-019 The start bit of frame 0 SHALL appear on sin in the cycle after acceptance.
REQ-020 In SEND, a bit counter SHALL run 0..10 and a frame counter 0..8, wrapping the bit counter at the end of each frame.
REQ-021 After frame 8, bit 10, the block SHALL pulse done in that same cycle and enter GAP.
REQ-022 GAP SHALL hold sin=1 for GAP_CYCLES cycles and then return to IDLE; back-to-back packets are therefore separated by GAP_CYCLES+1 idle-high cycles minimum (including the IDLE arbitration cycle).
REQ-023 Input changes during SEND or GAP SHALL be ignored; latched operands are held stable until the next acceptance.
REQ-024 busy SHALL be 1 in SEND and GAP and 0 in IDLE.
REQ-025 grant_id SHALL hold its value after done until the next acceptance.

Reset
REQ-026 While rst_n=0 at a clock edge, outputs SHALL be: sin=1, busy=0, done=0, ready=0, grant_id=0; last-grant=1; counters 0; state IDLE.
REQ-027 Reset mid-packet SHALL abort the packet: sin=1 from the next edge, no done pulse, and latched data discarded.

Configuration
REQ-028 Macro ALU_SCHED_CRC_INJ_EN defined: adds inputs req0_crc_err and req1_crc_err (1 bit each), latched on acceptance; if set, the transmitted crc SHALL be (crc+1) mod 16.
REQ-029 Macro ALU_SCHED_CRC_INJ_EN undefined: those ports SHALL be absent and the correct crc is always sent.

Structure
REQ-030 Shared package alu_pkg SHALL hold operation_t, DATA_TYPE/CMD_TYPE, FRAME_BITS=11, PKT_FRAMES=9 and function crc4_generate.
REQ-031 Sub-module alu_frame_ser SHALL hold the 11-bit frame load/shift register, driving sin and the end-of-frame strobe; alu_req_sched owns the FSM, arbiter and counters.

Verification
REQ-032 Reset: hold rst_n=0 for 2 cycles with req0_valid=1 -> sin=1, busy=0, ready=0 throughout.
REQ-033 Single request: req0, A=32'h1, B=32'h2, op=3'b100 -> 99-cycle packet, with frames 0-3 payload 00,00,00,02 (type 0) and frames 4-7 payload 00,00,00,01 (type 0).
REQ-034 Continuing REQ-033: the CMD frame has type 1 and payload {0,100,crc4_generate}; done pulses exactly once, on the 99th cycle.
REQ-035 Contention: both valid in the first IDLE cycle -> req0 is accepted first; req1 is accepted after done + GAP_CYCLES + 1 cycles, with grant_id 0 then 1.
REQ-036 Fairness: req1 is held valid and req0 is raised mid-packet -> next grant is req0, then req1 alternates.
REQ-037 Abort: rst_n=0 during frame 4 -> sin=1 next cycle and no done; a fresh request afterwards sends a complete correct packet.
REQ-038 With ALU_SCHED_CRC_INJ_EN: req0_crc_err=1 -> CMD crc field equals golden crc + 1 mod 16.
